// File: rtl/reg_dump_collector_pkg.sv
// Shared debug-dump definitions: default sizes, state encoding, helpers.
// Also holds the byte width used on the UART transmit handshake.
package reg_dump_collector_pkg;

  localparam int DBG_LEN   = 32;
  localparam int DBG_NB    = 5;
  localparam int DBG_NREGS = 32;
  localparam int UART_DW   = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_SEND   = 3'd2,
    S_WAIT   = 3'd3,
    S_NEXT   = 3'd4,
    S_FINISH = 3'd5
  } dump_state_e;

  function automatic int bytes_per_word(input int len);
    return len / UART_DW;
  endfunction

  function automatic int dump_words(input int nregs);
    return nregs + 1;
  endfunction

endpackage

// File: rtl/reg_dump_collector.sv
// Debug register dump: walks PC plus every architectural register and
// streams each word MSB byte first over the UART tx_start/tx_done handshake.
module reg_dump_collector
  import reg_dump_collector_pkg::*;
#(
  parameter int LEN   = DBG_LEN,
  parameter int NB    = DBG_NB,
  parameter int NREGS = DBG_NREGS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LEN-1:0]     pc_value,
  input  logic [LEN-1:0]     reg_data,
  input  logic               tx_done,
  output logic [NB-1:0]      reg_addr,
  output logic               debug_mode,
  output logic [UART_DW-1:0] tx_data,
  output logic               tx_start,
  output logic               busy,
  output logic               done
);

  localparam int BPW   = bytes_per_word(LEN);
  localparam int WORDS = dump_words(NREGS);
  localparam int WIW   = $clog2(WORDS);
  localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [WIW-1:0] LAST_WORD = WIW'(WORDS - 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);

  dump_state_e        state_q, state_d;
  logic [WIW-1:0]     word_idx_q, word_idx_d;
  logic [BCW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [LEN-1:0]     shift_q, shift_d;
  logic [NB-1:0]      reg_addr_q, reg_addr_d;
  logic [UART_DW-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic               dbg_q, dbg_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      reg_addr_q <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      dbg_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      reg_addr_q <= reg_addr_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      dbg_q      <= dbg_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    reg_addr_d = reg_addr_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    dbg_d      = dbg_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          word_idx_d = '0;
          reg_addr_d = '0;
          busy_d     = 1'b1;
          dbg_d      = 1'b1;
          state_d    = S_LATCH;
        end
      end
      S_LATCH: begin
        // reg_addr was registered a cycle ago, so reg_data is settled
        shift_d    = (word_idx_q == '0) ? pc_value : reg_data;
        byte_cnt_d = '0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        tx_data_d  = shift_q[LEN-1 -: UART_DW];
        tx_start_d = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          shift_d    = shift_q << UART_DW;
          byte_cnt_d = byte_cnt_q + BCW'(1);
          state_d    = (byte_cnt_q == LAST_BYTE) ? S_NEXT : S_SEND;
        end
      end
      S_NEXT: begin
        if (word_idx_q == LAST_WORD) begin
          state_d = S_FINISH;
        end else begin
          word_idx_d = word_idx_q + WIW'(1);
          reg_addr_d = NB'(word_idx_q);
          state_d    = S_LATCH;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        dbg_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign reg_addr   = reg_addr_q;
  assign debug_mode = dbg_q;
  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_reg_dump_collector.sv
// Bench for reg_dump_collector: UART responder model, byte scoreboard,
// table of dump scenarios plus reset and spurious-handshake sequences.
module tb_reg_dump_collector;

  localparam int NREGS = 32;
  localparam int NBYTE = 4 * (NREGS + 1);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pc_value = '0;
  logic [31:0] reg_data;
  logic        tx_done = 1'b0;
  logic [4:0]  reg_addr;
  logic        debug_mode;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic        done;

  logic [31:0] rbase = 32'h100;
  assign reg_data = rbase + 32'(reg_addr);

  reg_dump_collector dut (
    .clk(clk), .reset(reset), .start(start),
    .pc_value(pc_value), .reg_data(reg_data), .tx_done(tx_done),
    .reg_addr(reg_addr), .debug_mode(debug_mode), .tx_data(tx_data),
    .tx_start(tx_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [7:0] b; logic [4:0] a; } exp_t;
  exp_t sb[$];

  int sent_cnt = 0;
  int done_cnt = 0;
  int td_cnt = 0;
  int stab_err = 0;
  int dly = 2;
  bit dbl = 0;
  bit spur_req = 0;

  // UART tx model: answers each tx_start after dly cycles
  bit         pend = 0;
  int         cnt = 0;
  int         done_left = 0;
  logic [7:0] cap = '0;
  always @(negedge clk) begin
    if (reset) begin
      pend = 0; done_left = 0; tx_done = 1'b0;
    end else begin
      if (done_left > 0) begin
        done_left--; tx_done = 1'b1;
      end else tx_done = 1'b0;
      if (spur_req) begin
        tx_done = 1'b1; spur_req = 0;
      end
      if (tx_start) begin
        if (pend) stab_err++;
        pend = 1; cnt = dly; cap = tx_data;
      end
      if (pend && !tx_start) begin
        if (tx_data !== cap) stab_err++;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 0; tx_done = 1'b1; td_cnt++;
          done_left = dbl ? 1 : 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_start) begin
        exp_t e;
        sent_cnt++;
        if (sb.size() == 0) chk("sb_empty_on_tx_start", 1, 0);
        else begin
          e = sb.pop_front();
          chk("tx_data", 64'(tx_data), 64'(e.b));
          chk("reg_addr", 64'(reg_addr), 64'(e.a));
          chk("busy_dbg_on_tx", {busy, debug_mode}, 2'b11);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] base);
    for (int k = 0; k <= NREGS; k++) begin
      logic [31:0] w;
      exp_t e;
      w = (k == 0) ? pc : base + 32'(k - 1);
      for (int b = 0; b < 4; b++) begin
        e.b = w[31 - 8*b -: 8];
        e.a = (k == 0) ? 5'd0 : 5'(k - 1);
        sb.push_back(e);
      end
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] base;
    int dly;
    int restart_at;
    bit dbl;
    int exp_bytes;
    int exp_done;
    int exp_lat;
  } vec_t;

  task automatic run_dump(input vec_t v);
    int cyc;
    int lat;
    int budget;
    bit restarted;
    budget = NBYTE * (v.dly + 6) + 100;
    pc_value = v.pc; rbase = v.base; dly = v.dly; dbl = v.dbl;
    sent_cnt = 0; done_cnt = 0; stab_err = 0;
    push_exp(v.pc, v.base);
    @(negedge clk);
    start = 1'b1;
    cyc = 0; lat = -1; restarted = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) chk("busy_dbg_after_start", {busy, debug_mode}, 2'b11);
      if (lat < 0 && tx_start) lat = cyc;
      if (v.restart_at >= 0 && !restarted && sent_cnt == v.restart_at) begin
        start = 1'b1; restarted = 1;
      end
      if (done) break;
    end
    if (cyc >= budget) chk("dump_timeout", 1, 0);
    chk("busy_dbg_at_done", {busy, debug_mode}, 2'b00);
    chk("sb_drained", 64'(sb.size()), 0);
    chk("start_latency", 64'(lat), 64'(v.exp_lat));
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 0);
    repeat (5) @(negedge clk);
    chk("byte_count", 64'(sent_cnt), 64'(v.exp_bytes));
    chk("done_count", 64'(done_cnt), 64'(v.exp_done));
    chk("tx_stable_no_extra_start", 64'(stab_err), 0);
    sb.delete();
  endtask

  vec_t vecs[5];

  initial begin
    int w;
    vecs[0] = '{32'h0000_0040, 32'h100,       2, -1, 0, NBYTE, 1, 3};
    vecs[1] = '{32'hDEAD_BEEF, 32'hA5A5_0F00, 1, -1, 0, NBYTE, 1, 3};
    vecs[2] = '{32'h1234_5678, 32'h100,       2,  5, 0, NBYTE, 1, 3};
    vecs[3] = '{32'h0000_0040, 32'h100,       2, -1, 1, NBYTE, 1, 3};
    vecs[4] = '{32'hCAFE_F00D, 32'h100,     100, -1, 0, NBYTE, 1, 3};

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {reg_addr, debug_mode, tx_data, tx_start, busy, done}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // spurious tx_done while idle
    spur_req = 1;
    repeat (4) @(negedge clk);
    chk("idle_spurious", {busy, debug_mode, tx_start}, 0);
    chk("idle_spurious_bytes", 64'(sent_cnt), 0);

    for (int i = 0; i < 5; i++) run_dump(vecs[i]);

    // reset mid-dump after the 10th tx_done
    pc_value = 32'h0000_0040; rbase = 32'h100; dly = 2; dbl = 0;
    td_cnt = 0; done_cnt = 0;
    push_exp(32'h0000_0040, 32'h100);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (td_cnt < 10 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) chk("reset_wait_timeout", 1, 0);
    reset = 1'b1;
    #1;
    chk("reset_mid_outputs",
        {reg_addr, debug_mode, tx_data, tx_start, busy, done}, 0);
    repeat (3) @(negedge clk);
    chk("reset_mid_no_done", 64'(done_cnt), 0);
    reset = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    run_dump('{32'h8000_0001, 32'h200, 2, -1, 0, NBYTE, 1, 3});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
